// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// ALU operation codes and ALU B-source selects.
package cu_pkg;

    localparam logic [3:0] OP_RTYPE_MAX = 4'h6;
    localparam logic [3:0] OP_ADDI      = 4'h7;
    localparam logic [3:0] OP_LW        = 4'h8;
    localparam logic [3:0] OP_SW        = 4'h9;
    localparam logic [3:0] OP_BEQ       = 4'hA;
    localparam logic [3:0] OP_JMP       = 4'hB;
    localparam logic [3:0] OP_ILL_LO    = 4'hC;
    localparam logic [3:0] OP_ILL_HI    = 4'hE;
    localparam logic [3:0] OP_HALT      = 4'hF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ULA_ADD = 3'b000,
        ULA_SUB = 3'b001,
        ULA_AND = 3'b010,
        ULA_OR  = 3'b011,
        ULA_XOR = 3'b100,
        ULA_SLT = 3'b101,
        ULA_SRL = 3'b110
    } ula_t;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_ONE = 2'b10;

    // Which kind of ALU work the current state needs.
    typedef enum logic [1:0] {
        ALU_CLS_ADD,
        ALU_CLS_SUB,
        ALU_CLS_FUNCT
    } alu_cls_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OP_ILL_LO) && (op <= OP_ILL_HI);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Shared instruction/data memory request port driven by the control unit.
interface control_unit_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output adr_src, input mem_ack);
    modport slave  (input mem_req, input mem_we, input adr_src, output mem_ack);
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from state class and opcode function bits.
module alu_decoder
    import cu_pkg::*;
(
    input  alu_cls_t    cls,
    input  logic [2:0]  funct,
    output logic [2:0]  ula_control
);

    always_comb begin
        ula_control = ULA_ADD;
        case (cls)
            ALU_CLS_SUB:   ula_control = ULA_SUB;
            ALU_CLS_FUNCT: ula_control = funct;
            default:       ula_control = ULA_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit: fetch/decode/execute/memory/write-back sequencer.
// Define CU_PERF_CNT_EN to build the saturating retired-instruction counter.
module control_unit
    import cu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           instr,
    input  logic                  zero,
    control_unit_if.master        mem,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  pc_src,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic                  result_src,
    output logic [2:0]            ula_control,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal,
    output logic [15:0]           instr_count
);

    state_t     state, state_nx;
    alu_cls_t   alu_cls;
    logic       retire;
    logic [3:0] opcode;
    logic       unused_instr_bits;

    assign opcode            = instr[15:12];
    assign unused_instr_bits = ^instr[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_DECODE && is_illegal(opcode))
                illegal <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.adr_src = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        result_src  = 1'b0;
        alu_cls     = ALU_CLS_ADD;
        retire      = 1'b0;
        busy        = (state != S_IDLE) && (state != S_HALT);
        halted      = (state == S_HALT);

        case (state)
            S_IDLE: if (start) state_nx = S_FETCH;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = SRCB_ONE;
                // IR load and PC+1 fire in the ack cycle itself.
                if (mem.mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode <= OP_RTYPE_MAX) state_nx = S_EXEC_R;
                else begin
                    case (opcode)
                        OP_ADDI:       state_nx = S_EXEC_I;
                        OP_LW, OP_SW:  state_nx = S_MEM_ADDR;
                        OP_BEQ:        state_nx = S_BRANCH;
                        OP_JMP:        state_nx = S_JUMP;
                        OP_HALT:       state_nx = S_HALT;
                        default:       state_nx = S_HALT;
                    endcase
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_cls   = ALU_CLS_FUNCT;
                state_nx  = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_nx  = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_nx  = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ack) state_nx = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_src = 1'b1;
                retire     = 1'b1;
                state_nx   = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ack) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_cls   = ALU_CLS_SUB;
                pc_src    = 1'b1;
                pc_write  = zero;
                retire    = 1'b1;
                state_nx  = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 1'b1;
                retire   = 1'b1;
                state_nx = S_FETCH;
            end
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
    end

    alu_decoder u_alu_decoder (
        .cls         (alu_cls),
        .funct       (opcode[2:0]),
        .ula_control (ula_control)
    );

`ifdef CU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            instr_count <= '0;
        else if (retire && instr_count != '1)
            instr_count <= instr_count + 16'd1;
    end
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instr_count   = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level reference model
// queues expected per-cycle outputs; a negedge monitor pops and compares.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        zero = 1'b0;
    logic [15:0] instr = '0;
    logic        ir_write, pc_write, pc_src, reg_write, alu_src_a, result_src;
    logic [1:0]  alu_src_b;
    logic [2:0]  ula_control;
    logic        busy, halted, illegal;
    logic [15:0] instr_count;

    control_unit_if mif ();

    control_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instr       (instr),
        .zero        (zero),
        .mem         (mif),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .result_src  (result_src),
        .ula_control (ula_control),
        .busy        (busy),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ctl;
        logic [15:0] cnt;
        string       tag;
    } exp_t;

    exp_t        sbq[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [15:0] cnt_m = '0;
    logic [15:0] act;

    assign act = {mif.mem_req, mif.mem_we, mif.adr_src, ir_write, pc_write, pc_src,
                  reg_write, alu_src_a, alu_src_b, result_src, ula_control,
                  busy, halted, illegal};

    function automatic logic [15:0] pk(input bit req, input bit we, input bit adr,
                                       input bit irw, input bit pcw, input bit pcs,
                                       input bit rw, input bit asa, input logic [1:0] asb,
                                       input bit rs, input logic [2:0] ula,
                                       input bit bsy, input bit hlt, input bit ill);
        return {req, we, adr, irw, pcw, pcs, rw, asa, asb, rs, ula, bsy, hlt, ill};
    endfunction

    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
`ifdef CU_PERF_CNT_EN
        return (c == 16'hFFFF) ? c : c + 16'd1;
`else
        return c & 16'h0000;
`endif
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] r16();
        return 16'($urandom);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if (act !== e.ctl) begin
                miscompares++;
                $display("FAIL %s ctl: got %b expected %b at %0t", e.tag, act, e.ctl, $time);
            end
            vectors++;
            if (instr_count !== e.cnt) begin
                miscompares++;
                $display("FAIL %s instr_count: got %0d expected %0d at %0t", e.tag, instr_count, e.cnt, $time);
            end
        end
    end

    // One clock cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic cyc(input logic rn, input logic st, input logic [15:0] ins,
                       input logic z, input logic ack, input logic [15:0] ctl,
                       input string tag, input bit ret);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn;
        start = st;
        instr = ins;
        zero = z;
        mif.mem_ack = ack;
        if (!rn) cnt_m = '0;
        e.ctl = ctl;
        e.cnt = cnt_m;
        e.tag = tag;
        sbq.push_back(e);
        if (ret) cnt_m = cnt_inc(cnt_m);
    endtask

    task automatic reset_and_start();
        cyc(0, rb(), r16(), rb(), rb(), '0, "reset", 0);
        cyc(1, 0, r16(), rb(), 1, '0, "idle_ack_ignored", 0);
        cyc(1, 1, r16(), rb(), rb(), '0, "idle_start", 0);
    endtask

    task automatic run_instr(input logic [15:0] ins, input bit z,
                             input int unsigned fw, input int unsigned mw);
        logic [3:0] op;
        bit         ill;
        op = ins[15:12];
        for (int unsigned k = 0; k < fw; k++)
            cyc(1, rb(), r16(), rb(), 0, pk(1,0,0,0,0,0,0,0,2'b10,0,3'b000,1,0,0), "fetch_wait", 0);
        cyc(1, rb(), r16(), rb(), 1, pk(1,0,0,1,1,0,0,0,2'b10,0,3'b000,1,0,0), "fetch_ack", 0);
        cyc(1, rb(), ins, rb(), rb(), pk(0,0,0,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "decode", 0);
        if (op <= 4'h6) begin
            cyc(1, rb(), ins, rb(), rb(), pk(0,0,0,0,0,0,0,1,2'b00,0,op[2:0],1,0,0), "exec_r", 0);
            cyc(1, rb(), r16(), rb(), rb(), pk(0,0,0,0,0,0,1,0,2'b00,0,3'b000,1,0,0), "alu_wb", 1);
        end else if (op == 4'h7) begin
            cyc(1, rb(), ins, rb(), rb(), pk(0,0,0,0,0,0,0,1,2'b01,0,3'b000,1,0,0), "exec_i", 0);
            cyc(1, rb(), r16(), rb(), rb(), pk(0,0,0,0,0,0,1,0,2'b00,0,3'b000,1,0,0), "alu_wb", 1);
        end else if (op == 4'h8 || op == 4'h9) begin
            cyc(1, rb(), ins, rb(), rb(), pk(0,0,0,0,0,0,0,1,2'b01,0,3'b000,1,0,0), "mem_addr", 0);
            if (op == 4'h8) begin
                for (int unsigned k = 0; k < mw; k++)
                    cyc(1, rb(), r16(), rb(), 0, pk(1,0,1,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "mem_read_wait", 0);
                cyc(1, rb(), r16(), rb(), 1, pk(1,0,1,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "mem_read_ack", 0);
                cyc(1, rb(), r16(), rb(), rb(), pk(0,0,0,0,0,0,1,0,2'b00,1,3'b000,1,0,0), "mem_wb", 1);
            end else begin
                for (int unsigned k = 0; k < mw; k++)
                    cyc(1, rb(), r16(), rb(), 0, pk(1,1,1,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "mem_write_wait", 0);
                cyc(1, rb(), r16(), rb(), 1, pk(1,1,1,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "mem_write_ack", 1);
            end
        end else if (op == 4'hA) begin
            cyc(1, rb(), ins, z, rb(), pk(0,0,0,0,z,1,0,1,2'b00,0,3'b001,1,0,0), "branch", 1);
        end else if (op == 4'hB) begin
            cyc(1, rb(), ins, rb(), rb(), pk(0,0,0,0,1,1,0,0,2'b00,0,3'b000,1,0,0), "jump", 1);
        end else begin
            ill = (op != 4'hF);
            for (int unsigned k = 0; k < 4; k++)
                cyc(1, (k == 1) ? 1'b1 : rb(), r16(), rb(), rb(),
                    pk(0,0,0,0,0,0,0,0,2'b00,0,3'b000,0,1,ill), ill ? "halt_illegal" : "halt", 0);
        end
    endtask

    initial begin
        logic [3:0] op;
        mif.mem_ack = 1'b0;

        cyc(0, 1, r16(), 0, 1, '0, "reset", 0);
        cyc(0, 0, r16(), 0, 0, '0, "reset", 0);
        cyc(1, 0, r16(), 0, 0, '0, "idle", 0);
        cyc(1, 1, r16(), 0, 0, '0, "idle_start", 0);

        run_instr(16'h0123, 0, 0, 0);
        run_instr(16'h6ABC, 0, 0, 0);
        run_instr(16'h5ABC, 0, 1, 0);
        run_instr(16'h8123, 0, 0, 3);
        run_instr(16'hA123, 1, 0, 0);
        run_instr(16'hA123, 0, 0, 0);
        run_instr(16'hB000, 0, 0, 0);
        run_instr(16'h9123, 0, 0, 0);
        run_instr(16'h9123, 0, 2, 2);
        run_instr(16'h7123, 0, 0, 0);

        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 11));
            run_instr({op, 12'($urandom)}, rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        run_instr(16'hF000, 0, 0, 0);

        reset_and_start();
        run_instr(16'h2345, 0, 0, 0);
        run_instr(16'hC000, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            reset_and_start();
            op = 4'($urandom_range(12, 14));
            run_instr({op, 12'($urandom)}, 0, 1, 0);
        end

        // Abort a load while its memory read is still waiting for ack.
        reset_and_start();
        run_instr(16'h1111, 0, 0, 0);
        cyc(1, 0, r16(), 0, 1, pk(1,0,0,1,1,0,0,0,2'b10,0,3'b000,1,0,0), "fetch_ack", 0);
        cyc(1, 0, 16'h8456, 0, 0, pk(0,0,0,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "decode", 0);
        cyc(1, 0, 16'h8456, 0, 0, pk(0,0,0,0,0,0,0,1,2'b01,0,3'b000,1,0,0), "mem_addr", 0);
        cyc(1, 0, 16'h8456, 0, 0, pk(1,0,1,0,0,0,0,0,2'b00,0,3'b000,1,0,0), "mem_read_wait", 0);
        cyc(0, 0, 16'h8456, 0, 0, '0, "async_reset_mid_read", 0);
        cyc(1, 0, 16'h8456, 0, 1, '0, "late_ack_idle", 0);
        cyc(1, 0, 16'h8456, 0, 1, '0, "late_ack_idle", 0);
        cyc(1, 0, 16'h8456, 0, 0, '0, "idle", 0);

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
